// File: rtl/spram_pkg.sv
// spram_pkg: shared types, latency constants and byte-parity helper for spram_param.
package spram_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Even parity of one byte: the stored bit makes the 9-bit lane XOR to zero.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/spram_array.sv
// spram_array: raw word storage with per-lane write enable and a registered,
// hold-until-next-read output. Out-of-range addresses drop writes and read zero.
module spram_array #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned NB     = 1,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NB-1:0]          wen,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NB*LANE_W-1:0]   wdata,
  output logic [NB*LANE_W-1:0]   rdata
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [NB*LANE_W-1:0] mem [DEPTH];
  logic                 in_range;

  assign in_range = ({1'b0, addr} < DEPTH_V);

  // Per-lane write; storage itself is not reset (the init sequencer clears it).
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (wen[k] && in_range) begin
        mem[addr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  // Registered read, updated only on a read so the word holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/spram_param.sv
// spram_param: parametrised single-port RAM with valid/ready requests, byte
// enables, READ_LAT of 1 or 2, and a clear-on-reset init sequencer.
// Optional feature: define SPRAM_PARITY_EN to store and check per-byte even parity.
module spram_param
  import spram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                req_err_inj,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                par_err
);

  localparam int unsigned NB = DATA_W / 8;
`ifdef SPRAM_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif
  localparam int unsigned MEM_W = NB * LANE_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   init_cnt;
  logic                accept;
  logic [NB-1:0]       arr_wen;
  logic                arr_re;
  logic [ADDR_W-1:0]   arr_addr;
  logic [MEM_W-1:0]    arr_wdata;
  logic [MEM_W-1:0]    wword;
  logic [MEM_W-1:0]    rd_word;
  logic [DATA_W-1:0]   rd_data;
  logic                mism;
  logic                v1;

`ifndef SPRAM_PARITY_EN
  logic unused_err_inj;
  assign unused_err_inj = req_err_inj;
`endif

  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // Leave INIT on the cycle the clear counter writes the last location.
  always_comb begin
    state_nx = state;
    if (state == INIT && init_cnt == LAST) state_nx = RUN;
  end

  // Clear-address counter; parks at the last address until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == INIT && init_cnt != LAST) begin
      init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  // Pack request bytes into storage lanes, appending parity when compiled in.
  always_comb begin
    wword = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      wword[k*LANE_W +: 8] = req_wdata[k*8 +: 8];
`ifdef SPRAM_PARITY_EN
      wword[k*LANE_W + 8] = byte_par(req_wdata[k*8 +: 8]) ^ req_err_inj;
`endif
    end
  end

  // Port mux: the init sequencer owns the array in INIT, requests own it in RUN.
  always_comb begin
    arr_wen   = '0;
    arr_re    = 1'b0;
    arr_addr  = req_addr;
    arr_wdata = wword;
    if (state == INIT) begin
      arr_wen   = '1;
      arr_addr  = init_cnt;
      arr_wdata = '0;
    end else if (accept) begin
      arr_wen = req_we ? req_be : '0;
      arr_re  = !req_we;
    end
  end

  spram_array #(
    .LANE_W (LANE_W),
    .NB     (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wen   (arr_wen),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (rd_word)
  );

  // Unpack the read word and recompute parity across all lanes.
  always_comb begin
    rd_data = '0;
    mism    = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      rd_data[k*8 +: 8] = rd_word[k*LANE_W +: 8];
`ifdef SPRAM_PARITY_EN
      mism = mism | (byte_par(rd_word[k*LANE_W +: 8]) ^ rd_word[k*LANE_W + 8]);
`endif
    end
  end

  // First response stage tracks the array's registered read.
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= arr_re;
  end

  if (READ_LAT >= READ_LAT_MAX) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
    logic              p2;

    // Output register stage; data and parity flag hold between responses.
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
        p2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          d2 <= rd_data;
          p2 <= mism;
        end
      end
    end

    assign rsp_valid = v2;
    assign rsp_rdata = d2;
    assign par_err   = v2 & p2;
  end else begin : g_lat1
    assign rsp_valid = v1;
    assign rsp_rdata = rd_data;
    assign par_err   = v1 & mism;
  end

endmodule

// File: tb/tb_spram_param.sv
// tb_spram_param: directed bench for spram_param (DATA_W=16, DEPTH=12, READ_LAT=2)
// with a word/byte-level reference memory and a per-cycle output compare.
module tb_spram_param;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;
  localparam int unsigned LAT   = 2;
`ifdef SPRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic [DW/8-1:0] req_be = '0;
  logic            req_err_inj = 1'b0;
  logic            req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic            par_err;

  spram_param #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .READ_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .req_err_inj (req_err_inj),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array plus a per-byte "bad parity" flag,
  // and a list of pending responses stamped with the cycle they must appear.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          perr;
  } rsp_t;

  rsp_t            q[$];
  logic [DW-1:0]   mmem [DEPTH];
  logic [DW/8-1:0] mbad [DEPTH];
  int              cyc = 0;
  int              init_cnt_m = 0;
  bit              ready_m = 1'b0;
  bit              cur_v = 1'b0;
  bit              cur_perr = 1'b0;
  bit              started = 1'b0;
  logic [DW-1:0]   last_data = '0;

  always @(posedge clk) begin
    rsp_t r;
    bit   acc;
    cyc++;
    started = 1'b1;
    if (rst) begin
      ready_m    = 1'b0;
      init_cnt_m = 0;
      q.delete();
      last_data  = '0;
      cur_v      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mmem[i] = '0;
        mbad[i] = '0;
      end
    end else begin
      acc = ready_m && req_valid;
      if (!ready_m) begin
        init_cnt_m++;
        if (init_cnt_m == DEPTH) ready_m = 1'b1;
      end
      if (acc) begin
        if (req_we) begin
          if (req_addr < DEPTH) begin
            for (int k = 0; k < DW/8; k++) begin
              if (req_be[k]) begin
                mmem[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
                mbad[req_addr][k] = PAR & req_err_inj;
              end
            end
          end
        end else begin
          r.due = cyc + LAT - 1;
          if (req_addr < DEPTH) begin
            r.data = mmem[req_addr];
            r.perr = |mbad[req_addr];
          end else begin
            r.data = '0;
            r.perr = 1'b0;
          end
          q.push_back(r);
        end
      end
      cur_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        cur_v     = 1'b1;
        last_data = q[0].data;
        cur_perr  = q[0].perr;
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", req_ready, ready_m);
      chk("init_done", init_done, ready_m);
      chk("rsp_valid", rsp_valid, cur_v);
      chk("rsp_rdata", rsp_rdata, last_data);
      if (cur_v) chk("par_err", par_err, cur_perr);
    end
  end

  task automatic op(input logic v, input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW/8-1:0] be, input logic inj);
    req_valid   = v;
    req_we      = we;
    req_addr    = a;
    req_wdata   = d;
    req_be      = be;
    req_err_inj = inj;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Requests presented during INIT must be ignored; counts edges until ready.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 100) begin
      op(1'b1, 1'b1, '0, 16'hFFFF, 2'b11, 1'b1);
      n++;
    end
    chk(name, n, 12);
  endtask

  task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input logic ep, input string name);
    op(1'b1, 1'b0, a, '0, '0, 1'b0);
    repeat (LAT - 1) idle();
    chk({name, "_v"}, rsp_valid, 1);
    chk(name, rsp_rdata, exp);
    chk({name, "_pe"}, par_err, ep);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    wait_ready("init_len");

    for (int a = 0; a < 16; a++) op(1'b1, 1'b0, AW'(a), '0, '0, 1'b0);
    repeat (2) idle();
    read_lit(4'd0, 16'h0000, 1'b0, "clr0");

    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b1, AW'(i), DW'(i * i), 2'b11, 1'b0);
    for (int i = DEPTH - 1; i >= 0; i--) op(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
    repeat (2) idle();
    read_lit(4'd11, 16'h0079, 1'b0, "sq11");
    read_lit(4'd10, 16'h0064, 1'b0, "sq10");
    read_lit(4'd1,  16'h0001, 1'b0, "sq1");

    op(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0);
    op(1'b1, 1'b1, 4'd3, 16'h1234, 2'b01, 1'b0);
    read_lit(4'd3, 16'hAB34, 1'b0, "be_lo");
    op(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0);
    read_lit(4'd3, 16'hAB34, 1'b0, "be_none");
    op(1'b1, 1'b1, 4'd3, 16'h5600, 2'b10, 1'b0);
    read_lit(4'd3, 16'h5634, 1'b0, "be_hi");

    op(1'b1, 1'b1, 4'd5, 16'h0055, 2'b11, 1'b0);
    read_lit(4'd5, 16'h0055, 1'b0, "raw");

    op(1'b1, 1'b1, 4'd13, 16'hBEEF, 2'b11, 1'b0);
    read_lit(4'd13, 16'h0000, 1'b0, "oor13");
    read_lit(4'd12, 16'h0000, 1'b0, "oor12");
    read_lit(4'd1,  16'h0001, 1'b0, "after_oor");

    op(1'b1, 1'b1, 4'd7, 16'h003C, 2'b11, 1'b1);
    read_lit(4'd7, 16'h003C, PAR, "par_inj");
    op(1'b1, 1'b1, 4'd7, 16'h003C, 2'b11, 1'b0);
    read_lit(4'd7, 16'h003C, 1'b0, "par_clr");
    op(1'b1, 1'b1, 4'd8, 16'h1111, 2'b01, 1'b1);
    op(1'b1, 1'b1, 4'd8, 16'h2222, 2'b10, 1'b0);
    read_lit(4'd8, 16'h2211, PAR, "par_part");

    op(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    rst = 1'b1;
    idle();
    chk("rst_init_done", init_done, 0);
    chk("rst_valid", rsp_valid, 0);
    rst = 1'b0;
    wait_ready("reinit_len");
    read_lit(4'd3, 16'h0000, 1'b0, "rst_clr");

    repeat (3) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spram_param.md
# spram_param

Parametrised single-port RAM with a valid/ready request interface, separate write and read data buses, per-byte write enables, and a configurable read latency. On reset, a built-in initialisation sequencer clears every location. It replaces the fixed 16x8 bidirectional-bus RAM as the general storage primitive for the team's designs.

## Interface
- `DATA_W`, default 8: word width; must be a multiple of 8.
- `DEPTH`, default 16: number of words; any value ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `READ_LAT`, default 1: read latency in cycles; legal values are 1 and 2 (2 adds an output register).

Ports:
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `req_be`  in  DATA_W/8  byte enables, used for writes only.
- `req_err_inj`  in  1  invert the stored parity on this write (only active when parity is compiled in).
- `rsp_valid`  out  1  one-cycle pulse: read data is valid.
- `rsp_rdata`  out  DATA_W  read data; holds its value until the next response.
- `init_done`  out  1  high once the clear sequence has finished.
- `par_err`  out  1  parity mismatch on the current response; qualified by `rsp_valid`.

## Operation
- FSM states are INIT and RUN.
- INIT:
  - An internal counter steps from 0 to DEPTH-1, writing zero (with correct parity) to one location per cycle.
  - `req_ready`=0 throughout.
  - On the cycle the counter reaches DEPTH-1, the FSM moves to RUN.
- RUN:
  - `req_ready`=1 constantly.
  - A request is accepted when `req_valid && req_ready`.
- Write:
  - At the accept edge, byte k of `req_addr` is updated with byte k of `req_wdata` wherever `req_be[k]`=1.
  - `req_be`=0 is a legal no-op.
- Read:
  - Produces exactly one `rsp_valid` pulse.
  - There is no response backpressure. A read can be accepted every cycle, giving back-to-back responses.
- Only one operation happens per cycle (single port).
- Read-after-write to the same address on the next cycle returns the new data. No bypass is needed because the write has already completed at the accept edge.
- An out-of-range address (≥ DEPTH when DEPTH is not a power of 2) is handled as follows:
  - a write is dropped;
  - a read returns 0 with `rsp_valid` still asserted.
- Address arithmetic does not wrap; the block never increments the address except in INIT.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0, `par_err`=0, FSM=INIT, init counter=0.
- `rst` asserted at any time has the following effect:
  - the next edge returns the block to INIT;
  - in-flight read responses are discarded (no `rsp_valid`);
  - the clear sequence restarts from 0.
- Init duration: `init_done` and `req_ready` rise DEPTH cycles after the first edge with `rst` low.
- Read accepted at edge N:
  - `rsp_valid` is high during the cycle after edge N+READ_LAT-1.
  - That is, with READ_LAT=1 the data is visible right after edge N; with READ_LAT=2 it is visible one cycle later.
- `rsp_rdata` is not cleared between responses.
- `req_*` inputs are sampled only at accept edges; they are ignored during INIT.

## Configuration
- `SPRAM_PARITY_EN`:
  - When defined:
    - each byte gets a stored even-parity bit (memory width DATA_W + DATA_W/8);
    - `req_err_inj`=1 on a write stores inverted parity for every enabled byte;
    - on each read, parity is recomputed; `par_err`=1 alongside `rsp_valid` if any byte mismatches, with the same latency as the data.
  - When undefined:
    - no parity storage;
    - `req_err_inj` is ignored;
    - `par_err` is tied to 0.

## Structure
- Shared package `spram_pkg` holds:
  - the FSM state typedef (INIT, RUN);
  - the `READ_LAT` legal-value constants;
  - a byte-parity function.
- One sub-module, `spram_array`: the raw storage with per-byte write enable and a registered read. `spram_param` wraps it with the FSM, init counter, latency pipeline and parity check.

## Test plan
- Reset with DEPTH=16 → `req_ready`=0 for 16 cycles, then 1; reading all addresses returns 0x00.
- Write i*i to address i for i=0..15, then read i=15..0 → `rsp_rdata` = 0xE1, 0xC4, …, 0x01, 0x00, each with `rsp_valid` 1 cycle after the read (READ_LAT=1), 2 cycles with READ_LAT=2.
- DATA_W=16: write 0xABCD to address 3, then write 0x1234 with `req_be`=2'b01 → read returns 0xAB34.
- Write 0x55 to address 5 then read address 5 on the next cycle → 0x55. Back-to-back reads of 16 addresses → 16 consecutive `rsp_valid` pulses.
- Issue a read, then assert `rst` before `rsp_valid` → no response pulse; `init_done` falls to 0 and the clear sequence reruns.
- With `SPRAM_PARITY_EN`: write 0x3C to address 7 with `req_err_inj`=1 → reading address 7 gives `par_err`=1. Rewriting with `req_err_inj`=0 → `par_err`=0.
